// File: rtl/intersection_ctrl_if.sv
// intersection_ctrl_if: sensor/button inputs and lamp/status outputs of the intersection controller
interface intersection_ctrl_if;
  logic       tick;
  logic       side_req;
  logic       ped_btn;
  logic       main_r;
  logic       main_y;
  logic       main_g;
  logic       side_r;
  logic       side_y;
  logic       side_g;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;
  modport master (
    output tick, side_req, ped_btn,
    input  main_r, main_y, main_g, side_r, side_y, side_g, walk, ped_pending, phase
  );
  modport slave (
    input  tick, side_req, ped_btn,
    output main_r, main_y, main_g, side_r, side_y, side_g, walk, ped_pending, phase
  );
endinterface

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: main/side road right-of-way FSM with yellow, all-red clearance and pedestrian walk
module intersection_ctrl #(
  parameter int MIN_GREEN = 100,
  parameter int SIDE_MIN  = 50,
  parameter int SIDE_MAX  = 200,
  parameter int YELLOW    = 30,
  parameter int ALL_RED   = 10,
  parameter int WALK      = 40,
  parameter int CW        = 9
) (
  input logic clk,
  input logic rst,
  intersection_ctrl_if.slave bus
);
  typedef enum logic [2:0] {MG = 3'd0, MY = 3'd1, AR1 = 3'd2, SG = 3'd3, SY = 3'd4, AR2 = 3'd5} state_t;
  localparam logic [CW-1:0] MG_X   = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] Y_X    = CW'(YELLOW - 1);
  localparam logic [CW-1:0] AR_X   = CW'(ALL_RED - 1);
  localparam logic [CW-1:0] SMIN_X = CW'(SIDE_MIN - 1);
  localparam logic [CW-1:0] SMAX_X = CW'(SIDE_MAX - 1);
  localparam logic [CW-1:0] WALK_L = CW'(WALK);
  state_t        state_q, state_d;
  logic [CW-1:0] el_q, el_d;
  logic          ped_q, ped_d;
  logic          wc_q, wc_d;
  logic [6:0]    out_q, out_d;
  logic          enter_sg;
  // next phase: exits are taken only on tick at the listed elapsed counts; illegal codes fall to AR2
  always_comb begin
    state_d = state_q;
    case (state_q)
      MG:      state_d = (bus.tick && el_q >= MG_X && (bus.side_req || ped_q)) ? MY : MG;
      MY:      state_d = (bus.tick && el_q == Y_X) ? AR1 : MY;
      AR1:     state_d = (bus.tick && el_q == AR_X) ? SG : AR1;
      SG:      state_d = (bus.tick && el_q >= SMIN_X && (!bus.side_req || el_q == SMAX_X)) ? SY : SG;
      SY:      state_d = (bus.tick && el_q == Y_X) ? AR2 : SY;
      AR2:     state_d = (bus.tick && el_q == AR_X) ? MG : AR2;
      default: state_d = AR2;
    endcase
  end
  // elapsed counter, pedestrian latch/walk capture and lamp decode of the next phase
  always_comb begin
    enter_sg = state_q == AR1 && state_d == SG;
    el_d     = state_d != state_q ? '0 : (bus.tick && el_q != '1) ? el_q + CW'(1) : el_q;
    ped_d    = enter_sg ? 1'b0 : ped_q | bus.ped_btn;
    wc_d     = enter_sg ? ped_q | bus.ped_btn : state_d == SG && wc_q;
    out_d    = {state_d inside {AR1, SG, SY, AR2}, state_d == MY, state_d == MG,
                state_d inside {MG, MY, AR1, AR2}, state_d == SY, state_d == SG,
                state_d == SG && wc_d && el_d < WALK_L};
  end
  // state and registered outputs; reset lands directly in main green
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MG;
      el_q    <= '0;
      ped_q   <= 1'b0;
      wc_q    <= 1'b0;
      out_q   <= 7'b0011000;
    end else begin
      state_q <= state_d;
      el_q    <= el_d;
      ped_q   <= ped_d;
      wc_q    <= wc_d;
      out_q   <= out_d;
    end
  end
  assign {bus.main_r, bus.main_y, bus.main_g, bus.side_r, bus.side_y, bus.side_g, bus.walk} = out_q;
  assign bus.ped_pending = ped_q;
  assign bus.phase       = state_q;
endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: randomized stimulus, tick-level reference model and scoreboard monitor
module tb_intersection_ctrl;
  localparam int MIN_GREEN = 4, SIDE_MIN = 3, SIDE_MAX = 6, YELLOW = 2, ALL_RED = 1, WALK = 2;
  localparam int NCYC = 6600;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  intersection_ctrl_if bus();
  intersection_ctrl #(
    .MIN_GREEN(MIN_GREEN), .SIDE_MIN(SIDE_MIN), .SIDE_MAX(SIDE_MAX),
    .YELLOW(YELLOW), .ALL_RED(ALL_RED), .WALK(WALK), .CW(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [10:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int ph = 0;
  int n = 0;
  bit pend = 0;
  bit wc = 0;
  function automatic logic [10:0] expect_now();
    return {ph >= 2, ph == 1, ph == 0, ph != 3 && ph != 4, ph == 4, ph == 3,
            ph == 3 && wc && n < WALK, pend, 3'(ph)};
  endfunction
  task automatic step(input bit r, input bit t, input bit s, input bit b);
    bit leave;
    leave = 0;
    if (r) begin
      ph = 0; n = 0; pend = 0; wc = 0;
      return;
    end
    if (t) begin
      case (ph)
        0:       leave = n + 1 >= MIN_GREEN && (s || pend);
        1, 4:    leave = n + 1 == YELLOW;
        2, 5:    leave = n + 1 == ALL_RED;
        default: leave = n + 1 >= SIDE_MIN && (!s || n + 1 == SIDE_MAX);
      endcase
    end
    if (leave && ph == 2) begin
      wc = pend | b;
      pend = 0;
    end else pend = pend | b;
    if (leave && ph == 3) wc = 0;
    if (leave) begin
      ph = (ph + 1) % 6;
      n = 0;
    end else if (t) n++;
  endtask
  initial begin
    bit r, t, s, b, sg_rst_done;
    int mode;
    sg_rst_done = 0;
    mode = 0;
    bus.tick = 0; bus.side_req = 0; bus.ped_btn = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      t = cyc % 4 == 3;
      r = 0; s = 0; b = 0;
      if (cyc < 4) r = 1;
      else if (cyc < 204) s = 0;
      else if (cyc < 444) s = 1;
      else begin
        if (cyc % 64 == 0) mode = $urandom_range(0, 2);
        s = mode == 2 ? 1'($urandom_range(0, 1)) : mode == 1;
        b = $urandom_range(0, 39) == 0;
        if (ph == 2 && t) b = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 599) == 0;
        if (!sg_rst_done && ph == 3 && n == 1) begin
          r = 1;
          sg_rst_done = 1;
        end
      end
      rst = r; bus.tick = t; bus.side_req = s; bus.ped_btn = b;
      step(r, t, s, b);
      exp_q.push_back(expect_now());
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    logic [10:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {bus.main_r, bus.main_y, bus.main_g, bus.side_r, bus.side_y, bus.side_g,
               bus.walk, bus.ped_pending, bus.phase};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL outputs t=%0t: got {mr,my,mg,sr,sy,sg,walk,pend,phase}=%b required %b", $time, got, e);
        end
        checks++;
        if (!bus.main_r && !bus.side_r) begin
          failures++;
          $display("FAIL conflict t=%0t: main_r=%b side_r=%b, required at least one red", $time, bus.main_r, bus.side_r);
        end
      end
    end
  end
endmodule

// File: doc/intersection_ctrl.md
# intersection_ctrl

Two-approach traffic intersection controller that shares right-of-way between a main road and a side road. It drives a red/yellow/green lamp set for each approach plus a pedestrian walk signal, with guaranteed yellow and all-red clearance between conflicting greens. Phase durations are counted in ticks of a 0.1 s enable pulse. The block sits above the per-lamp drive logic and arbitrates green time between the side-road vehicle sensor and the pedestrian push-button.

## Interface

Parameters:
- MIN_GREEN, 100: minimum main-road green, in ticks
- SIDE_MIN, 50: minimum side-road green, in ticks
- SIDE_MAX, 200: maximum side-road green, in ticks
- YELLOW, 30: yellow duration, in ticks, both approaches
- ALL_RED, 10: all-red clearance, in ticks
- WALK, 40: walk duration, in ticks, at the start of side green
- CW, 9: width of the elapsed-tick counter
- Legal ranges: all durations ≥1 and <2^CW; WALK ≤ SIDE_MIN ≤ SIDE_MAX.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle 0.1 s enable pulse; all timing advances only on tick
- side_req  in  1  side-road vehicle sensor, level
- ped_btn  in  1  pedestrian button; any high cycle counts as a press
- main_r, main_y, main_g  out  1 each  main-road lamps
- side_r, side_y, side_g  out  1 each  side-road lamps
- walk  out  1  pedestrian walk lamp, for crossing the main road
- ped_pending  out  1  pedestrian request latched, not yet served
- phase  out  3  current state encoding, for debug

## Operation

- States: MG (main green), MY (main yellow), AR1 (all red), SG (side green), SY (side yellow), AR2 (all red). Order: MG→MY→AR1→SG→SY→AR2→MG.
- Lamps are Moore outputs of the state. In MG, MY, and AR1/AR2, side_r=1. In SG, SY, and AR1/AR2, main_r=1. Exactly one lamp per approach is lit at any time.
- Elapsed counter `el`:
  - Cleared on every state change.
  - Otherwise increments on tick, saturating at 2^CW−1.
- All transitions are evaluated only in cycles where tick=1. The exit tick is the tick at which `el` equals the value given below; D ticks are spent in the state.
  - MG→MY: `el` ≥ MIN_GREEN−1 and (side_req or ped_pending). With no request, MG holds indefinitely.
  - MY→AR1 and SY→AR2: `el` == YELLOW−1.
  - AR1→SG and AR2→MG: `el` == ALL_RED−1.
  - SG→SY: `el` ≥ SIDE_MIN−1, and either side_req=0 or `el` == SIDE_MAX−1. side_req is sampled on the exit tick, so a held sensor extends SG up to SIDE_MAX.
- Pedestrian handling:
  - ped_pending is set by ped_btn in any cycle.
  - On the cycle of the AR1→SG transition, walk_cycle is set to ped_pending|ped_btn and ped_pending is cleared. A press in that same cycle is served in this SG.
  - A press during SG, SY, or AR2 stays pending for the next cycle.
  - walk=1 iff state==SG, walk_cycle=1, and `el` < WALK. walk_cycle clears on leaving SG.
- Reset values:
  - state=MG, `el`=0, ped_pending=0, walk_cycle=0.
  - Outputs: main_g=1, side_r=1, all other lamps 0, walk=0.
- Reset mid-operation, including during SG or a yellow phase, returns to MG on the next cycle with no yellow or all-red. Upstream power-on sequencing guarantees that this is safe.
- An illegal phase encoding recovers to AR2 so that clearance is preserved.

## Timing

- Lamp, walk and phase outputs change in the clk cycle after the qualifying tick cycle (registered state, decoded outputs).
- ped_pending goes high one cycle after ped_btn.
- tick=0 freezes `el` and state. Inputs other than rst and ped_btn are ignored in non-tick cycles.
- side_req glitches between ticks have no effect.
- Worst-case wait for side service after a request in MG: MIN_GREEN + YELLOW + ALL_RED ticks.

## Test plan

Params for all scenarios: MIN_GREEN=4, SIDE_MIN=3, SIDE_MAX=6, YELLOW=2, ALL_RED=1, WALK=2, tick every 4 clk.

- Reset, no requests, 50 ticks → main_g=1 and side_r=1 throughout; walk=0, ped_pending=0.
- side_req held high from reset → MG 4 ticks, MY 2, AR1 1, SG 6 (capped at max), SY 2, AR2 1, then MG. Repeats while held; no cycle has both approaches non-red.
- side_req pulsed for 1 tick in MG at `el`=1 → MY at the 4th tick (ped/side latching not required for side_req), but only if side_req is high at the exit tick. If low at that tick, MG holds. Also verify that with side_req high during MG and low from SG entry, SG lasts exactly 3 ticks.
- ped_btn pulse, side_req=0 → ped_pending=1 next cycle. The sequence reaches SG, where walk=1 for the first 2 ticks, SG lasts 3 ticks, and ped_pending clears on SG entry.
- ped_btn asserted in the exact AR1→SG transition cycle → served in this SG (walk=1), and ped_pending=0 afterward.
- rst asserted for one cycle mid-SG (`el`=1) → next cycle main_g=1, side_r=1, walk=0, ped_pending=0, phase=MG, and the MG minimum restarts from 0.
